// File: rtl/shift_normalizer_if.sv
// Request/response bundle for shift_normalizer.
// The requester drives start/mode/operand. The normalizer drives busy/done/result/amount/zero.
interface shift_normalizer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AMT_W = 6
);
  logic             start;
  logic [1:0]       mode;
  logic [XLEN-1:0]  operand;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  logic [AMT_W-1:0] amount;
  logic             zero;

  modport master (
    output start, mode, operand,
    input  busy, done, result, amount, zero
  );

  modport slave (
    input  start, mode, operand,
    output busy, done, result, amount, zero
  );
endinterface

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer that resolves one binary shift stage (16/8/4/2/1) per clock.
// Mode 00 and mode 11 count leading zeros. Mode 01 counts trailing zeros.
// Mode 10 counts redundant sign bits when NORM_CLS_EN is defined. Otherwise mode 10 acts as mode 00.
module shift_normalizer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AMT_W = 6
) (
  input logic                clk,
  input logic                rst_n,
  shift_normalizer_if.slave  bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StS16  = 3'd1;
  localparam logic [2:0] StS8   = 3'd2;
  localparam logic [2:0] StS4   = 3'd3;
  localparam logic [2:0] StS2   = 3'd4;
  localparam logic [2:0] StS1   = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  localparam logic [XLEN-1:0] AllOnes = '1;

  logic [2:0]       state_q, state_d;
  logic [XLEN-1:0]  work_q, work_d;
  logic [AMT_W-1:0] acc_q, acc_d;
  logic             right_q, right_d;
  logic             zero_lat_q, zero_lat_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [AMT_W-1:0] amount_q, amount_d;
  logic             zero_q, zero_d;
`ifdef NORM_CLS_EN
  logic             cls_q, cls_d;
  logic [XLEN-1:0]  sign_mask;
  logic             hit_cls;
`endif

  logic [4:0]       stage_k;
  logic [XLEN-1:0]  top_mask, bot_mask;
  logic             hit_left, hit_right, stage_hit;
  logic [XLEN-1:0]  work_stage;
  logic [AMT_W-1:0] acc_stage;
  logic             accept;

  // Shift distance that the current state tests.
  always_comb begin
    stage_k = 5'd0;
    unique case (state_q)
      StS16:   stage_k = 5'd16;
      StS8:    stage_k = 5'd8;
      StS4:    stage_k = 5'd4;
      StS2:    stage_k = 5'd2;
      StS1:    stage_k = 5'd1;
      default: stage_k = 5'd0;
    endcase
  end

  // Test the current stage and compute the work register and accumulator after it.
  always_comb begin
    top_mask  = ~(AllOnes >> stage_k);
    bot_mask  = ~(AllOnes << stage_k);
    hit_left  = (work_q & top_mask) == '0;
    hit_right = (work_q & bot_mask) == '0;
    stage_hit = right_q ? hit_right : hit_left;
`ifdef NORM_CLS_EN
    // CLS tests k+1 top bits, so a lone sign bit is never shifted out.
    sign_mask = ~(AllOnes >> ({1'b0, stage_k} + 6'd1));
    hit_cls   = ((work_q & sign_mask) == '0) || ((work_q & sign_mask) == sign_mask);
    if (cls_q) stage_hit = hit_cls;
`endif
    work_stage = work_q;
    acc_stage  = acc_q;
    if (stage_hit) begin
      work_stage = right_q ? (work_q >> stage_k) : (work_q << stage_k);
      acc_stage  = acc_q + {1'b0, stage_k};
    end
  end

  assign accept = bus.start && ((state_q == StIdle) || (state_q == StDone));

  // Sequencing, request latch and result update.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    acc_d      = acc_q;
    right_d    = right_q;
    zero_lat_d = zero_lat_q;
    result_d   = result_q;
    amount_d   = amount_q;
    zero_d     = zero_q;
`ifdef NORM_CLS_EN
    cls_d      = cls_q;
`endif
    if (accept) begin
      state_d    = StS16;
      work_d     = bus.operand;
      acc_d      = '0;
      right_d    = (bus.mode == 2'b01);
      zero_lat_d = (bus.operand == '0);
`ifdef NORM_CLS_EN
      cls_d      = (bus.mode == 2'b10);
      if (bus.mode == 2'b10) zero_lat_d = (bus.operand == '0) || (bus.operand == AllOnes);
`endif
    end else begin
      unique case (state_q)
        StS16, StS8, StS4, StS2: begin
          work_d  = work_stage;
          acc_d   = acc_stage;
          state_d = state_q + 3'd1;
        end
        StS1: begin
          work_d   = work_stage;
          acc_d    = acc_stage;
          state_d  = StDone;
          result_d = work_stage;
          zero_d   = zero_lat_q;
          // A zero operand reports a full-width shift. CLS keeps the 31 it accumulated.
          amount_d = zero_lat_q ? AMT_W'(XLEN) : acc_stage;
`ifdef NORM_CLS_EN
          if (cls_q) amount_d = acc_stage;
`endif
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers. Reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      work_q     <= '0;
      acc_q      <= '0;
      right_q    <= 1'b0;
      zero_lat_q <= 1'b0;
      result_q   <= '0;
      amount_q   <= '0;
      zero_q     <= 1'b0;
`ifdef NORM_CLS_EN
      cls_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      acc_q      <= acc_d;
      right_q    <= right_d;
      zero_lat_q <= zero_lat_d;
      result_q   <= result_d;
      amount_q   <= amount_d;
      zero_q     <= zero_d;
`ifdef NORM_CLS_EN
      cls_q      <= cls_d;
`endif
    end
  end

  assign bus.busy   = (state_q != StIdle) && (state_q != StDone);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.amount = amount_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer using directed vectors with hand-computed results.
module tb_shift_normalizer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_normalizer_if bus ();

  shift_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [5:0]  amt;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pop one expectation for every done pulse.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", bus.result, mon_e.res);
        chk("amount", {26'b0, bus.amount}, {26'b0, mon_e.amt});
        chk("zero", {31'b0, bus.zero}, {31'b0, mon_e.z});
        chk("latency_cycle", cyc, mon_e.cyc);
      end
      chk("done_one_cycle", {31'b0, done_prev}, 32'd0);
    end
    done_prev = bus.done;
  end

  // Called at a negedge. Drives start across one posedge and queues the expected result.
  task automatic issue(input logic [31:0] op, input logic [1:0] md, input logic push,
                       input logic [31:0] er, input logic [5:0] ea, input logic ez);
    exp_t e;
    bus.start   = 1'b1;
    bus.mode    = md;
    bus.operand = op;
    if (push) begin
      e.res = er;
      e.amt = ea;
      e.z   = ez;
      e.cyc = cyc + 6;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic run(input logic [31:0] op, input logic [1:0] md,
                     input logic [31:0] er, input logic [5:0] ea, input logic ez);
    issue(op, md, 1'b1, er, ea, ez);
    repeat (7) @(negedge clk);
  endtask

  task automatic chk_zeroed(input string tag);
    chk({tag, "_busy"},   {31'b0, bus.busy}, 32'd0);
    chk({tag, "_done"},   {31'b0, bus.done}, 32'd0);
    chk({tag, "_result"}, bus.result, 32'd0);
    chk({tag, "_amount"}, {26'b0, bus.amount}, 32'd0);
    chk({tag, "_zero"},   {31'b0, bus.zero}, 32'd0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.mode    = 2'b00;
    bus.operand = 32'h0;
    #2;
    chk_zeroed("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(32'h0001_0000, 2'b00, 32'h8000_0000, 6'd15, 1'b0);
    run(32'h0001_0000, 2'b01, 32'h0000_0001, 6'd16, 1'b0);
    run(32'h8000_0000, 2'b01, 32'h0000_0001, 6'd31, 1'b0);
    run(32'h0000_0000, 2'b00, 32'h0000_0000, 6'd32, 1'b1);
    run(32'h8000_0000, 2'b00, 32'h8000_0000, 6'd0,  1'b0);
    run(32'h0000_0000, 2'b01, 32'h0000_0000, 6'd32, 1'b1);
    run(32'h0000_0006, 2'b01, 32'h0000_0003, 6'd1,  1'b0);
    run(32'h00F0_0000, 2'b11, 32'hF000_0000, 6'd8,  1'b0);
`ifdef NORM_CLS_EN
    run(32'hFFFF_0000, 2'b10, 32'h8000_0000, 6'd15, 1'b0);
    run(32'h0000_7FFF, 2'b10, 32'h7FFF_0000, 6'd16, 1'b0);
    run(32'hFFFF_FFFF, 2'b10, 32'h8000_0000, 6'd31, 1'b1);
    run(32'h0000_0000, 2'b10, 32'h0000_0000, 6'd31, 1'b1);
`else
    run(32'hFFFF_0000, 2'b10, 32'hFFFF_0000, 6'd0,  1'b0);
`endif

    // A second start during S8 must be ignored. A start in the DONE cycle is accepted.
    issue(32'h0000_0001, 2'b00, 1'b1, 32'h8000_0000, 6'd31, 1'b0);
    repeat (2) @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = 2'b00;
    bus.operand = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_during_ignored_start", {31'b0, bus.busy}, 32'd1);
    repeat (4) @(negedge clk);
    chk("done_before_back_to_back", {31'b0, bus.done}, 32'd1);
    issue(32'h0000_0100, 2'b00, 1'b1, 32'h8000_0000, 6'd23, 1'b0);
    repeat (7) @(negedge clk);

    // Asynchronous reset in S4 clears outputs immediately, and no done follows.
    issue(32'h0000_0010, 2'b01, 1'b0, 32'h0, 6'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zeroed("async_reset");
    #2;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run(32'h0000_0010, 2'b01, 32'h0000_0001, 6'd4, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
